// File: rtl/cv_pkg.sv
// Shared constants and types for the convolution weights datapath.
package cv_pkg;

    localparam int CV_WROW_W  = 512;
    localparam int CV_WADR_W  = 11;
    localparam int CV_WBEAT_W = 64;

    localparam logic CV_MODE_8BIT = 1'b0;
    localparam logic CV_MODE_1BIT = 1'b1;

    localparam int BEATS_PER_ROW = CV_WROW_W / CV_WBEAT_W;

    typedef enum logic [1:0] {
        WL_IDLE   = 2'd0,
        WL_LOAD   = 2'd1,
        WL_FINISH = 2'd2
    } wl_state_e;

endpackage

// File: rtl/cv_weights_row_packer.sv
// Beat counter plus assembly register: packs IN_WIDTH beats LSB-first into one row.
module cv_weights_row_packer #(
    parameter int IN_WIDTH  = 64,
    parameter int ROW_WIDTH = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 beat_push,
    input  logic [IN_WIDTH-1:0]  beat_data,
    output logic                 row_full,
    output logic [ROW_WIDTH-1:0] row_data
);

    localparam int BEATS = ROW_WIDTH / IN_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    logic [BW-1:0]        cnt_q, cnt_d;
    logic [ROW_WIDTH-1:0] asm_q, asm_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        row_full = 1'b0;
        if (clear) begin
            cnt_d = '0;
            asm_d = '0;
        end else if (beat_push) begin
            asm_d[cnt_q*IN_WIDTH +: IN_WIDTH] = beat_data;
            if (cnt_q == LAST) begin
                cnt_d    = '0;
                row_full = 1'b1;
            end else begin
                cnt_d = cnt_q + BW'(1);
            end
        end
    end

    // Exposing the next value lets the parent capture the row including the final beat.
    assign row_data = asm_d;

endmodule

// File: rtl/cv_weights_loader.sv
// Loads N weight rows from a 64-bit stream into the weights buffer starting at a base row.
module cv_weights_loader
    import cv_pkg::*;
#(
    parameter int IN_WIDTH   = CV_WBEAT_W,
    parameter int ROW_WIDTH  = CV_WROW_W,
    parameter int ADDR_WIDTH = CV_WADR_W,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_start,
    input  logic [ADDR_WIDTH-1:0] cmd_base_adr,
    input  logic [CNT_WIDTH-1:0]  cmd_rows,
    output logic                  busy,
    output logic                  done,
    input  logic                  hold,
    input  logic [IN_WIDTH-1:0]   s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  wb_we,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [ROW_WIDTH-1:0]  wb_din
);

    wl_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  rows_q;
    logic                  wb_we_q;
    logic [ADDR_WIDTH-1:0] wb_addr_q;
    logic [ROW_WIDTH-1:0]  wb_din_q;

    logic                  start_ok;
    logic                  beat_push;
    logic                  row_full;
    logic [ROW_WIDTH-1:0]  row_data;

    // Handshake: a beat transfers on a rising edge where s_valid & s_ready;
    // s_ready is only high in LOAD with hold low, and s_valid is never waited on with a timeout.
    assign start_ok  = (state_q == WL_IDLE) && cmd_start;
    assign beat_push = s_valid && s_ready;

    cv_weights_row_packer #(
        .IN_WIDTH  (IN_WIDTH),
        .ROW_WIDTH (ROW_WIDTH)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .beat_push (beat_push),
        .beat_data (s_data),
        .row_full  (row_full),
        .row_data  (row_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= WL_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WL_IDLE:   if (cmd_start) state_d = (cmd_rows == '0) ? WL_FINISH : WL_LOAD;
            WL_LOAD:   if (row_full && rows_q == CNT_WIDTH'(1)) state_d = WL_FINISH;
            // First FINISH cycle carries the last write; done follows once it has drained.
            WL_FINISH: if (!wb_we_q) state_d = WL_IDLE;
            default:   state_d = WL_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        s_ready = 1'b0;
        unique case (state_q)
            WL_LOAD: begin
                busy    = 1'b1;
                s_ready = ~hold;
            end
            WL_FINISH: begin
                busy = wb_we_q;
                done = ~wb_we_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            rows_q    <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_din_q  <= '0;
        end else begin
            wb_we_q <= row_full;
            if (start_ok) begin
                addr_q <= cmd_base_adr;
                rows_q <= cmd_rows;
            end else if (row_full) begin
                wb_addr_q <= addr_q;
                wb_din_q  <= row_data;
                addr_q    <= addr_q + ADDR_WIDTH'(1);
                rows_q    <= rows_q - CNT_WIDTH'(1);
            end
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_addr = wb_addr_q;
    assign wb_din  = wb_din_q;

endmodule

// File: tb/tb_cv_weights_loader.sv
// Bench for cv_weights_loader: vector table, random commands and hand-written corner sequences.
module tb_cv_weights_loader;

    localparam int IW  = 64;
    localparam int RW  = 512;
    localparam int AW  = 11;
    localparam int CW  = 12;
    localparam int BPR = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_start;
    logic [AW-1:0] cmd_base_adr;
    logic [CW-1:0] cmd_rows;
    logic          busy, done, hold;
    logic [IW-1:0] s_data;
    logic          s_valid, s_ready;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [RW-1:0] wb_din;

    cv_weights_loader dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_start    (cmd_start),
        .cmd_base_adr (cmd_base_adr),
        .cmd_rows     (cmd_rows),
        .busy         (busy),
        .done         (done),
        .hold         (hold),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_din       (wb_din)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [AW+RW-1:0] exp_q[$];
    logic [IW-1:0]    beats[$];
    int               wr_cnt = 0;
    int               done_cnt = 0;
    int               last_wr_addr = 0;
    int               last_we_cycle = 0;
    int               last_done_cycle = 0;
    logic [RW-1:0]    last_din = '0;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        logic [AW+RW-1:0] e;
        @(negedge clk);
        if (reset === 1'b1 && wb_we === 1'b1) begin
            wr_cnt++;
            last_we_cycle = cycle;
            last_wr_addr  = int'(wb_addr);
            last_din      = wb_din;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=addr %0d required=no write", wb_addr);
            end else begin
                e = exp_q.pop_front();
                check_int("wb_addr", int'(wb_addr), int'(e[AW+RW-1:RW]));
                check_vec("wb_din", wb_din, e[RW-1:0]);
            end
        end
        if (reset === 1'b1 && done === 1'b1) begin
            done_cnt++;
            last_done_cycle = cycle;
            check_int("busy_low_with_done", int'(busy), 0);
        end
    end

    // Reference: row r of a command is beats 8r..8r+7, beat 0 in the low bits, at (base+r) mod 2048.
    task automatic model_rows(input int base, input int rows);
        logic [RW-1:0] row;
        logic [AW-1:0] a;
        for (int r = 0; r < rows; r++) begin
            row = '0;
            for (int k = 0; k < BPR; k++) row[k*IW +: IW] = beats[r*BPR + k];
            a = AW'((base + r) % (1 << AW));
            exp_q.push_back({a, row});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        beats.delete();
        for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom});
    endtask

    task automatic send_beats(input int n, input int gap, input int hold_at, input int hold_len,
                              input int start_at);
        int i = 0;
        int budget = 0;
        int hold_left = 0;
        bit held = 0;
        bit started = 0;
        while (i < n) begin
            if (budget > 60 * n + 100) begin
                checks++;
                failures++;
                $display("FAIL beat_timeout actual=%0d beats required=%0d beats", i, n);
                break;
            end
            cmd_start = 1'b0;
            hold      = 1'b0;
            if (!held && hold_len > 0 && i == hold_at) begin
                held      = 1;
                hold_left = hold_len;
            end
            if (!started && start_at >= 0 && i == start_at) begin
                started      = 1;
                cmd_start    = 1'b1;
                cmd_base_adr = AW'(7);
                cmd_rows     = CW'(1);
            end
            s_valid = ($urandom_range(99) >= gap);
            s_data  = beats[i];
            if (hold_left > 0) begin
                hold    = 1'b1;
                s_valid = 1'b1;
                hold_left--;
            end
            @(negedge clk);
            if (hold) check_int("s_ready_during_hold", int'(s_ready), 0);
            else if (s_valid) check_int("s_ready_in_load", int'(s_ready), 1);
            if (s_valid && s_ready) i++;
            tick();
            budget++;
        end
        cmd_start = 1'b0;
        s_valid   = 1'b0;
        hold      = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_int("done_within_budget", int'(done_cnt != d0), 1);
        tick();
    endtask

    task automatic run_cmd(input int base, input int rows, input int gap, input int hold_at,
                           input int hold_len, input int start_at);
        int d0;
        int sc;
        d0 = done_cnt;
        model_rows(base, rows);
        cmd_base_adr = AW'(base);
        cmd_rows     = CW'(rows);
        cmd_start    = 1'b1;
        sc           = cycle;
        tick();
        cmd_start = 1'b0;
        send_beats(rows * BPR, gap, hold_at, hold_len, start_at);
        if (rows > 0) begin
            check_int("s_ready_low_after_last", int'(s_ready), 0);
            check_int("we_in_first_finish", int'(wb_we), 1);
        end
        wait_done(d0);
        repeat (3) tick();
        check_int("done_once", done_cnt - d0, 1);
        check_int("sb_drained", exp_q.size(), 0);
        if (gap == 0 && hold_len == 0 && start_at < 0)
            check_int("done_latency", last_done_cycle - sc, (rows == 0) ? 1 : 8 * rows + 2);
        if (rows > 0) check_int("we_to_done", last_done_cycle - last_we_cycle, 1);
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int base;
        int rows;
        int gap;
        int hold_at;
        int hold_len;
        int start_at;
        int exp_writes;
        int exp_last;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int d0;
        int w0;
        int base;
        int rows;

        vecs[0] = '{0,    1, 0,  -1, 0, -1, 1, 0};
        vecs[1] = '{2046, 3, 0,  -1, 0, -1, 3, 0};
        vecs[2] = '{100,  2, 30, 11, 5, -1, 2, 101};
        vecs[3] = '{5,    0, 0,  -1, 0, -1, 0, 0};
        vecs[4] = '{1000, 4, 0,  -1, 0, 12, 4, 1003};
        vecs[5] = '{2047, 2, 25, 4,  5, -1, 2, 0};
        vecs[6] = '{512,  5, 40, 20, 7, -1, 5, 516};

        reset        = 1'b0;
        cmd_start    = 1'b0;
        cmd_base_adr = '0;
        cmd_rows     = '0;
        hold         = 1'b0;
        s_data       = '0;
        s_valid      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check_int("rst_s_ready", int'(s_ready), 0);
        check_int("rst_wb_we", int'(wb_we), 0);
        check_int("rst_wb_addr", int'(wb_addr), 0);
        check_vec("rst_wb_din", wb_din, '0);
        reset = 1'b1;
        tick();

        // Single row with patterned beats 0x00..0 .. 0x77..7
        beats.delete();
        for (int k = 0; k < BPR; k++) beats.push_back(IW'(64'h1111_1111_1111_1111 * k));
        run_cmd(0, 1, 0, -1, 0, -1);
        check_vec("row_low_beat", RW'(last_din[63:0]), RW'(beats[0]));
        check_vec("row_high_beat", RW'(last_din[511:448]), RW'(beats[7]));
        check_int("single_row_addr", last_wr_addr, 0);

        // Mode1 sub-row layout with distinct random halves
        fill_random(BPR);
        run_cmd(33, 1, 0, -1, 0, -1);
        for (int p = 0; p < 4; p++)
            check_vec("mode1_subrow", RW'(last_din[128*p +: 128]), RW'({beats[2*p+1], beats[2*p]}));

        for (int v = 0; v < 7; v++) begin
            w0 = wr_cnt;
            fill_random(vecs[v].rows * BPR);
            run_cmd(vecs[v].base, vecs[v].rows, vecs[v].gap, vecs[v].hold_at, vecs[v].hold_len,
                    vecs[v].start_at);
            check_int("vec_write_count", wr_cnt - w0, vecs[v].exp_writes);
            if (vecs[v].exp_writes > 0) check_int("vec_last_addr", last_wr_addr, vecs[v].exp_last);
        end

        // Randomized commands against the model
        for (int t = 0; t < 5; t++) begin
            base = $urandom_range(2047);
            rows = $urandom_range(1, 3);
            w0   = wr_cnt;
            fill_random(rows * BPR);
            run_cmd(base, rows, $urandom_range(0, 40), $urandom_range(0, rows * BPR - 1),
                    $urandom_range(0, 4), -1);
            check_int("rand_write_count", wr_cnt - w0, rows);
            check_int("rand_last_addr", last_wr_addr, (base + rows - 1) % 2048);
        end

        // Zero rows: done in the very next cycle, no write
        d0 = done_cnt;
        w0 = wr_cnt;
        cmd_base_adr = AW'(9);
        cmd_rows     = '0;
        cmd_start    = 1'b1;
        tick();
        cmd_start = 1'b0;
        @(negedge clk);
        check_int("zero_done_next", int'(done), 1);
        check_int("zero_busy", int'(busy), 0);
        repeat (4) tick();
        check_int("zero_no_write", wr_cnt - w0, 0);
        check_int("zero_done_once", done_cnt - d0, 1);

        // cmd_start in the done cycle is ignored
        d0 = done_cnt;
        fill_random(BPR);
        model_rows(10, 1);
        cmd_base_adr = AW'(10);
        cmd_rows     = CW'(1);
        cmd_start    = 1'b1;
        tick();
        cmd_start = 1'b0;
        send_beats(BPR, 0, -1, 0, -1);
        tick();
        cmd_base_adr = AW'(55);
        cmd_rows     = CW'(2);
        cmd_start    = 1'b1;
        @(negedge clk);
        check_int("done_cycle_done", int'(done), 1);
        tick();
        cmd_start = 1'b0;
        repeat (5) tick();
        check_int("start_in_done_ignored_busy", int'(busy), 0);
        check_int("start_in_done_ignored_done", done_cnt - d0, 1);
        check_int("start_in_done_sb", exp_q.size(), 0);

        // Reset abort after beat 11 of a two-row command
        d0 = done_cnt;
        fill_random(2 * BPR);
        model_rows(300, 1);
        cmd_base_adr = AW'(300);
        cmd_rows     = CW'(2);
        cmd_start    = 1'b1;
        tick();
        cmd_start = 1'b0;
        send_beats(11, 0, -1, 0, -1);
        check_int("abort_first_row_written", exp_q.size(), 0);
        #2;
        reset = 1'b0;
        #1;
        check_int("abort_busy", int'(busy), 0);
        check_int("abort_done", int'(done), 0);
        check_int("abort_s_ready", int'(s_ready), 0);
        check_int("abort_wb_we", int'(wb_we), 0);
        check_int("abort_wb_addr", int'(wb_addr), 0);
        check_vec("abort_wb_din", wb_din, '0);
        w0      = wr_cnt;
        s_valid = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (20) begin
            s_data = {$urandom, $urandom};
            tick();
        end
        s_valid = 1'b0;
        check_int("abort_no_write", wr_cnt - w0, 0);
        check_int("abort_no_done", done_cnt - d0, 0);

        fill_random(BPR);
        run_cmd(700, 1, 10, -1, 0, -1);
        check_int("after_abort_addr", last_wr_addr, 700);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cv_weights_loader.md
Name: cv_weights_loader

Overview:
- Upstream feeder of the convolution weights read path.
- Accepts a 64-bit valid/ready weight stream (from the DMA/AXI unpacker) and assembles 8 beats into one 512-bit weights row.
- Writes each row into the weights buffer write port at base + row index, one command at a time.
- Row bit layout is mode-agnostic: a 1-bit (mode1) row holds four 128-bit sub-rows. Beat order therefore fixes the sub-row order that the read side selects with part_select 0..3.

Parameters:
- IN_WIDTH, 64, stream beat width in bits.
- ROW_WIDTH, 512, weights buffer row width; must be a multiple of IN_WIDTH.
- BEATS_PER_ROW, ROW_WIDTH/IN_WIDTH = 8, derived; not overridable.
- ADDR_WIDTH, 11, weights buffer address width (2048 rows).
- CNT_WIDTH, 12, row-count width; allows 0..2048.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle command strobe; ignored while busy=1.
- cmd_base_adr  in  ADDR_WIDTH  first buffer row to write.
- cmd_rows  in  CNT_WIDTH  number of rows to load.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- hold  in  1  read side active; blocks stream acceptance.
- s_data  in  IN_WIDTH  stream beat.
- s_valid  in  1  beat valid.
- s_ready  out  1  beat accepted when s_valid & s_ready at a rising edge.
- wb_we  out  1  buffer write enable.
- wb_addr  out  ADDR_WIDTH  buffer write address.
- wb_din  out  ROW_WIDTH  buffer write data.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: busy=0, done=0, s_ready=0, wb_we=0, wb_addr=0, wb_din=0. Beat counter, row counter and assembly register are cleared.
- FSM states: IDLE, LOAD, FINISH.
- IDLE:
  - On cmd_start=1, latch cmd_base_adr into the address counter and cmd_rows into the remaining-row counter.
  - If cmd_rows=0, go to FINISH. Otherwise go to LOAD.
  - busy=1 from the cycle after cmd_start.
- LOAD:
  - s_ready = ~hold (combinational).
  - Beat k (0..7) of a row is stored at bits [k*64 +: 64]. Beat 0 is the least significant, so beats 0-1 form mode1 sub-row 0 and beats 6-7 form sub-row 3.
  - On accepting beat 7: the next cycle drives wb_we=1, wb_addr = current address, wb_din = the completed row (beat 7 included).
  - In the same edge, the address increments modulo 2^ADDR_WIDTH (2047 wraps to 0) and the remaining-row counter decrements.
  - Each write holds wb_we for exactly one cycle. Back-to-back rows give wb_we pulses spaced 8 cycles apart with no bubble beyond the beats themselves.
  - When beat 7 of the last row is accepted, s_ready deasserts from the next cycle and the FSM goes to FINISH.
- FINISH:
  - For non-zero cmd_rows, the final wb_we occurs in the first FINISH cycle.
  - done=1 for one cycle in the following cycle, and busy=0 in that same cycle. The FSM then returns to IDLE.
  - For cmd_rows=0, done pulses in the cycle after cmd_start, with no writes.
- hold:
  - Gates acceptance only. The assembly register and beat count are preserved across hold.
  - A write already registered is still issued. The read side must assert hold before beginning re_fm_en.
- s_valid=0 stalls LOAD indefinitely with no timeout.
- cmd_start while busy=1, including the done cycle, is ignored.
- Reset mid-command: immediate abort. The partial row is discarded, no write is issued and no done pulse is produced.
- Latency: a command of N rows finishes with done at least 8N+2 cycles after cmd_start.

Decomposition:
- Shared package cv_pkg holds:
  - CV_WROW_W=512, CV_WADR_W=11, CV_WBEAT_W=64;
  - CV_MODE_8BIT=1'b0, CV_MODE_1BIT=1'b1;
  - localparam BEATS_PER_ROW.
- One sub-module, cv_weights_row_packer: the beat counter plus the 512-bit assembly register.
  - Inputs: beat_push, beat_data, clear.
  - Outputs: row_full pulse, row_data.
- The FSM, address counter and row counter stay in cv_weights_loader.

Test Plan:
- Single row: base=0, rows=1, beats 0x0..0 through 0x7..7 with no gaps -> one wb_we at addr 0; wb_din[63:0]=beat0 and wb_din[511:448]=beat7; done 1 cycle after wb_we; busy low with done.
- Wrap: base=2046, rows=3, 24 continuous beats -> writes at addresses 2046, 2047, 0 in order; done once.
- Hold/valid stalls: rows=2, random s_valid gaps, hold asserted for 5 cycles mid-row -> s_ready=0 throughout hold, row contents unchanged, both rows correct at base and base+1.
- Zero rows and ignored start: cmd_rows=0 -> done in the next cycle with no wb_we. A second cmd_start during a 4-row load -> ignored, exactly 4 writes.
- Reset abort: rows=2, assert reset after beat 11 -> all outputs 0 immediately, no further wb_we, no done. A new command with rows=1 afterwards loads correctly.
- Mode1 layout: 8 beats with distinct 128-bit halves -> wb_din[128*p +: 128] equals {beat(2p+1), beat(2p)} for p=0..3.
